pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer for the single-cycle MIPS core. Replaces the

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the core control logic and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  // Control from the core
  logic             stall;
  logic             exception;
  logic             branch;
  logic             zero;
  logic [WIDTH-1:0] immed;
  logic             jump;
  logic [25:0]      jump_index;
  logic             jump_reg;
  logic [WIDTH-1:0] reg_target;
  logic             call;
  logic             ret;
  // Status back to the core; *_c are combinational
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4_c;
  logic             redirect;
  logic             ras_empty;
  logic             ras_full;
  logic             misaligned_c;

  modport master (
    output stall, exception, branch, zero, immed, jump, jump_index,
           jump_reg, reg_target, call, ret,
    input  pc, pc_plus4_c, redirect, ras_empty, ras_full, misaligned_c
  );

  modport slave (
    input  stall, exception, branch, zero, immed, jump, jump_index,
           jump_reg, reg_target, call, ret,
    output pc, pc_plus4_c, redirect, ras_empty, ras_full, misaligned_c
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch/jump/jr/exception redirect and a
// circular return-address stack for call/return prediction.
module pc_sequencer #(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h8000_0180),
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  pc_sequencer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] reg_aligned;
  logic             ras_empty;
  logic             ras_full;
  logic             misaligned;
  logic             pop_valid;

  // Link value, word-aligned register target and stack status
  always_comb begin
    pc_plus4    = pc_q + WIDTH'(4);
    reg_aligned = {bus.reg_target[WIDTH-1:2], 2'b00};
    ras_empty   = (cnt_q == '0);
    ras_full    = (cnt_q == CNT_W'(RAS_DEPTH));
    pop_valid   = bus.ret && !ras_empty;
  end

  // Next-PC selection and return-address stack update
  always_comb begin
    pc_d       = pc_plus4;
    redirect_d = 1'b0;
    misaligned = 1'b0;
    top_d      = top_q;
    cnt_d      = cnt_q;
    ras_d      = ras_q;

    if (bus.exception) begin
      pc_d       = EXC_VECTOR;
      redirect_d = 1'b1;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      if (pop_valid) begin
        pc_d       = ras_q[top_q];
        redirect_d = 1'b1;
      end else if (bus.ret || bus.jump_reg) begin
        pc_d       = reg_aligned;
        redirect_d = 1'b1;
        misaligned = |bus.reg_target[1:0];
      end else if (bus.jump) begin
        pc_d       = {pc_plus4[WIDTH-1:28], bus.jump_index, 2'b00};
        redirect_d = 1'b1;
      end else if (bus.branch && bus.zero) begin
        pc_d       = pc_plus4 + (bus.immed << 2);
        redirect_d = 1'b1;
      end

      // A call that also returns swaps the top entry in place
      if (pop_valid && bus.call) begin
        ras_d[top_q] = pc_plus4;
      end else if (pop_valid) begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else if (bus.call && (bus.jump || bus.jump_reg)) begin
        top_d        = top_q + PTR_W'(1);
        ras_d[top_d] = pc_plus4;
        if (!ras_full) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      top_q      <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      ras_q      <= ras_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4_c   = pc_plus4;
  assign bus.redirect     = redirect_q;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;
  assign bus.misaligned_c = misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_pc_sequencer;

  localparam int unsigned RAS_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0180;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH     (32),
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VEC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_red;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_pc  = RESET_PC;
    m_red = 1'b0;
    m_ras.delete();
  endtask

  function automatic logic exp_mis();
    if (bus.exception || bus.stall) return 1'b0;
    if ((bus.ret && m_ras.size() == 0) || (!bus.ret && bus.jump_reg))
      return |bus.reg_target[1:0];
    return 1'b0;
  endfunction

  // Advance the model by one clock edge from the currently driven inputs
  task automatic model_edge();
    logic [31:0] p4;
    logic [31:0] tgt;
    p4 = m_pc + 32'd4;
    if (bus.exception) begin
      m_pc  = EXC_VEC;
      m_red = 1'b1;
    end else if (bus.stall) begin
      m_red = 1'b0;
    end else begin
      m_red = 1'b1;
      if (bus.ret && m_ras.size() != 0) tgt = m_ras[m_ras.size()-1];
      else if (bus.ret || bus.jump_reg) tgt = {bus.reg_target[31:2], 2'b00};
      else if (bus.jump) tgt = {p4[31:28], bus.jump_index, 2'b00};
      else if (bus.branch && bus.zero) tgt = p4 + (bus.immed << 2);
      else begin
        tgt   = p4;
        m_red = 1'b0;
      end
      if (bus.ret && m_ras.size() != 0) begin
        if (bus.call) m_ras[m_ras.size()-1] = p4;
        else void'(m_ras.pop_back());
      end else if (bus.call && (bus.jump || bus.jump_reg)) begin
        m_ras.push_back(p4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
      m_pc = tgt;
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.exception = 0; bus.branch = 0; bus.zero = 0;
    bus.immed = '0; bus.jump = 0; bus.jump_index = '0; bus.jump_reg = 0;
    bus.reg_target = '0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic goto_pc(input logic [31:0] a);
    bus.jump_reg = 1; bus.reg_target = a;
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1;
    #1;
    model_reset();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst = 1; idle(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.pc !== RESET_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, RESET_PC); end
    total++; if (bus.redirect !== 1'b0 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
      bad++; $display("FAIL reset_flags got red=%b e=%b f=%b exp 0 1 0", bus.redirect, bus.ras_empty, bus.ras_full); end
    rst = 0;
    tick(); tick();
    rst = 1;
    #1;
    total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL reset_async got=%h exp=0", bus.pc); end
    model_reset();
    #1 rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'(4 * i);
      total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL reset_seq%0d got=%h exp=%h", i, bus.pc, exp_pc); end
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h100);
    bus.branch = 1; bus.zero = 1; bus.immed = 32'hFFFF_FFFE;
    tick();
    total++; if (bus.pc !== 32'hFC || bus.redirect !== 1'b1) begin
      bad++; $display("FAIL branch_taken got pc=%h red=%b exp pc=fc red=1", bus.pc, bus.redirect); end
    goto_pc(32'h100);
    bus.branch = 1; bus.zero = 0; bus.immed = 32'hFFFF_FFFE;
    tick();
    total++; if (bus.pc !== 32'h104 || bus.redirect !== 1'b0) begin
      bad++; $display("FAIL branch_not_taken got pc=%h red=%b exp pc=104 red=0", bus.pc, bus.redirect); end
  endtask

  task automatic test_jump();
    goto_pc(32'h0040_0010);
    bus.jump = 1; bus.jump_index = 26'h000_0040;
    tick();
    total++; if (bus.pc !== 32'h100 || bus.redirect !== 1'b1) begin
      bad++; $display("FAIL jump got pc=%h red=%b exp pc=100 red=1", bus.pc, bus.redirect); end
    bus.jump_reg = 1; bus.reg_target = 32'h203;
    #1;
    total++; if (bus.misaligned_c !== 1'b1) begin bad++; $display("FAIL jr_misaligned got=%b exp=1", bus.misaligned_c); end
    tick();
    total++; if (bus.pc !== 32'h200) begin bad++; $display("FAIL jr_target got=%h exp=200", bus.pc); end
  endtask

  task automatic test_ras_call_return();
    logic [31:0] exp_ret [3];
    exp_ret[0] = 32'h84; exp_ret[1] = 32'h44; exp_ret[2] = 32'h14;
    pulse_reset();
    goto_pc(32'h10);
    bus.call = 1; bus.jump = 1; bus.jump_index = 26'h10;  tick();
    bus.call = 1; bus.jump = 1; bus.jump_index = 26'h20;  tick();
    bus.call = 1; bus.jump = 1; bus.jump_index = 26'h100; tick();
    total++; if (bus.pc !== 32'h400 || bus.ras_empty !== 1'b0) begin
      bad++; $display("FAIL ras_calls got pc=%h empty=%b exp pc=400 empty=0", bus.pc, bus.ras_empty); end
    for (int i = 0; i < 3; i++) begin
      bus.ret = 1; bus.reg_target = 32'hDEAD_BEE0;
      tick();
      total++; if (bus.pc !== exp_ret[i]) begin bad++; $display("FAIL ras_pop%0d got=%h exp=%h", i, bus.pc, exp_ret[i]); end
    end
    total++; if (bus.ras_empty !== 1'b1) begin bad++; $display("FAIL ras_empty got=%b exp=1", bus.ras_empty); end
    bus.ret = 1; bus.reg_target = 32'h300;
    tick();
    total++; if (bus.pc !== 32'h300) begin bad++; $display("FAIL ras_fallback got=%h exp=300", bus.pc); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_pop;
    pulse_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.call = 1; bus.jump = 1; bus.jump_index = 26'(32'h40 * i);
      tick();
    end
    total++; if (bus.ras_full !== 1'b1 || bus.ras_empty !== 1'b0) begin
      bad++; $display("FAIL ras_full got full=%b empty=%b exp 1 0", bus.ras_full, bus.ras_empty); end
    for (int i = 0; i < 4; i++) begin
      bus.ret = 1; bus.reg_target = 32'h0;
      tick();
      exp_pop = 32'h404 - 32'(32'h100 * i);
      total++; if (bus.pc !== exp_pop) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus.pc, exp_pop); end
    end
    total++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
      bad++; $display("FAIL ovf_empty got empty=%b full=%b exp 1 0", bus.ras_empty, bus.ras_full); end
  endtask

  task automatic test_stall_exception();
    pulse_reset();
    goto_pc(32'h20);
    bus.call = 1; bus.jump = 1; bus.jump_index = 26'h40; tick();
    bus.stall = 1; bus.call = 1; bus.jump = 1; bus.jump_index = 26'h80;
    tick();
    total++; if (bus.pc !== 32'h100 || bus.redirect !== 1'b0) begin
      bad++; $display("FAIL stall_hold got pc=%h red=%b exp pc=100 red=0", bus.pc, bus.redirect); end
    bus.stall = 1; bus.exception = 1; bus.ret = 1;
    tick();
    total++; if (bus.pc !== EXC_VEC || bus.redirect !== 1'b1) begin
      bad++; $display("FAIL exc_over_stall got pc=%h red=%b exp pc=%h red=1", bus.pc, bus.redirect, EXC_VEC); end
    bus.ret = 1;
    tick();
    total++; if (bus.pc !== 32'h24 || bus.ras_empty !== 1'b1) begin
      bad++; $display("FAIL ras_kept got pc=%h empty=%b exp pc=24 empty=1", bus.pc, bus.ras_empty); end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      bus.stall      = ($urandom_range(0, 9) == 0);
      bus.exception  = ($urandom_range(0, 24) == 0);
      bus.branch     = ($urandom_range(0, 3) == 0);
      bus.zero       = $urandom_range(0, 1) == 1;
      bus.immed      = 32'($urandom_range(0, 64)) - 32'd32;
      bus.jump       = ($urandom_range(0, 4) == 0);
      bus.jump_index = 26'($urandom);
      bus.jump_reg   = ($urandom_range(0, 5) == 0);
      bus.reg_target = $urandom;
      bus.call       = ($urandom_range(0, 2) == 0);
      bus.ret        = ($urandom_range(0, 4) == 0);
      #1;
      total++; if (bus.misaligned_c !== exp_mis() || bus.pc_plus4_c !== m_pc + 32'd4) begin
        bad++; $display("FAIL rnd_comb n=%0d got mis=%b p4=%h exp mis=%b p4=%h",
                        n, bus.misaligned_c, bus.pc_plus4_c, exp_mis(), m_pc + 32'd4); end
      tick();
      total++; if (bus.pc !== m_pc || bus.redirect !== m_red) begin
        bad++; $display("FAIL rnd_pc n=%0d got pc=%h red=%b exp pc=%h red=%b", n, bus.pc, bus.redirect, m_pc, m_red); end
      total++; if (bus.ras_empty !== (m_ras.size() == 0) || bus.ras_full !== (m_ras.size() == RAS_DEPTH)) begin
        bad++; $display("FAIL rnd_ras n=%0d got e=%b f=%b exp size=%0d", n, bus.ras_empty, bus.ras_full, m_ras.size()); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_branch();
    test_jump();
    test_ras_call_return();
    test_ras_overflow();
    test_stall_exception();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
